reaction_timer_multiround: RTL and testbench
============================================

Name: reaction_timer_multiround

Overview:
Multi-round reaction timer controller that replaces the single-shot FSM plus its external wait timers.
- Generates its own pseudo-random foreperiod, millisecond timebase and penalty waits.
- Runs a session of ROUNDS trials and reports per-round, best and average reaction times.
- Sits between the debounced button front end and the RGB LED / seven-segment display drivers.

Parameters:
TICKS_PER_MS, 100000, clk cycles per 1 ms tick (100 MHz board clock)
ROUNDS, 4, trials per session; must be a power of two, 1..64
RT_W, 14, width of all millisecond results
TIMEOUT_MS, 1000, STIM duration after which the trial is late
PENALTY_MS, 5000, duration of the EARLY and LATE penalty displays
RWAIT_MIN_MS, 1000, minimum foreperiod
RWAIT_SPAN_LOG2, 12, random foreperiod extension is 0..2^RWAIT_SPAN_LOG2-1 ms
LFSR_SEED, 16'hACE1, non-zero LFSR reset value

Ports:
clk  in  1  system clock
RESET  in  1  asynchronous, active-low reset
start  in  1  one-cycle pulse, synchronised and debounced
enter  in  1  one-cycle pulse, synchronised and debounced
color_r  out  3  LED red level
color_g  out  3  LED green level
color_b  out  3  LED blue level
result_ms  out  RT_W  last completed round time
result_valid  out  1  one-cycle pulse when result_ms updates
best_ms  out  RT_W  minimum round time this session
avg_ms  out  RT_W  session sum / ROUNDS, valid in SUMMARY
round_idx  out  clog2(ROUNDS)+1  completed rounds this session
busy  out  1  high in RWAIT, STIM, EARLY, LATE
early  out  1  high in EARLY
late  out  1  high in LATE

Behaviour:
Reset and timebase
- Reset (RESET=0) takes effect immediately. State goes to IDLE.
- All outputs reset to 0, except best_ms, which resets to all-ones.
- The LFSR resets to LFSR_SEED. The sum and counters reset to 0.
- The prescaler emits ms_tick every TICKS_PER_MS cycles and free-runs.
- The ms counter clears on every state entry and increments on ms_tick. It saturates at all-ones.
- The LFSR (16-bit Galois, taps 16,14,13,11) advances every clk.

States, colours (r,g,b) and transitions
- IDLE (0,0,0): start -> RWAIT. Entry into RWAIT from IDLE clears the sum, round_idx and best_ms.
- RWAIT (0,0,0): on entry, latch target = RWAIT_MIN_MS + LFSR[RWAIT_SPAN_LOG2-1:0].
  - ms counter == target -> STIM.
  - else enter -> EARLY.
  - Expiry has priority over enter in the same cycle.
- STIM (2,2,2):
  - enter -> SHOW, with result = current ms count.
  - else ms counter == TIMEOUT_MS -> LATE, with result = TIMEOUT_MS.
  - Enter has priority over timeout in the same cycle.
- EARLY (1,0,0): after PENALTY_MS -> RWAIT with the same round_idx. No result is recorded.
- LATE (3,3,0): after PENALTY_MS -> SHOW. The TIMEOUT_MS result counts as a round.
- SHOW (0,2,0): start -> RWAIT if round_idx < ROUNDS, else -> SUMMARY.
- SUMMARY (0,0,2): start -> RWAIT, which begins a new session and clears stats as above.
- enter is ignored in IDLE, SHOW and SUMMARY. start is ignored in busy states.

Recording a round
- Happens in the cycle the round result is fixed (STIM->SHOW on enter, or LATE entry).
- result_ms <= result and result_valid pulses.
- sum += result. The sum is RT_W+clog2(ROUNDS) bits and cannot overflow.
- round_idx += 1.
- best_ms <= min(best_ms, result).
- avg_ms <= sum >> clog2(ROUNDS), registered on SUMMARY entry. It holds until the next session clear.
- Latency: result visible 1 cycle after the enter pulse.

Decomposition:
- Package reaction_timer_pkg holds:
  - state_t enum: IDLE, RWAIT, STIM, EARLY, LATE, SHOW, SUMMARY (3-bit).
  - RGB colour constants per state.
  - The LFSR tap constant.
- One sub-module, rt_lfsr16: seed parameter, enable, 16-bit state output.
- The prescaler, ms counter and statistics stay in the top module.

Test Plan:
Bench parameters: TICKS_PER_MS=4, ROUNDS=2, TIMEOUT_MS=20, PENALTY_MS=5, RWAIT_MIN_MS=3, RWAIT_SPAN_LOG2=2.
1. Normal session: start, wait for STIM, enter at ms 7, then start, enter at ms 11 -> results 7 and 11, result_valid pulsed twice, best_ms=7, then start -> SUMMARY with avg_ms=9 and colours 0,0,2.
2. Early press: enter 1 ms into RWAIT -> EARLY (1,0,0) for 5 ms, back to RWAIT, round_idx stays 0, no result_valid.
3. Late: no enter in STIM -> LATE at ms 20 (3,3,0), SHOW after 5 ms, result_ms=20, round_idx=1.
4. Simultaneous events:
   - enter in the RWAIT expiry cycle -> STIM, not EARLY.
   - enter in the STIM timeout cycle -> SHOW with result 20, never LATE.
5. Reset mid-STIM: RESET low asynchronously -> outputs 0 and best_ms=all-ones within the same cycle. After release, start -> a fresh session with round_idx 0.
6. Odd-rounding average: results 4 and 7 -> avg_ms=5 (truncate). Ignored inputs: start in STIM and enter in SHOW cause no state change.

Source files
------------

// File: rtl/reaction_timer_pkg.sv
// Shared types and constants for the multi-round reaction timer.
package reaction_timer_pkg;

   typedef enum logic [2:0] {
      IDLE, RWAIT, STIM, EARLY, LATE, SHOW, SUMMARY
   } state_t;

   typedef struct packed {
      logic [2:0] r;
      logic [2:0] g;
      logic [2:0] b;
   } rgb_t;

   localparam rgb_t RGB_OFF   = '{r: 3'd0, g: 3'd0, b: 3'd0};
   localparam rgb_t RGB_STIM  = '{r: 3'd2, g: 3'd2, b: 3'd2};
   localparam rgb_t RGB_EARLY = '{r: 3'd1, g: 3'd0, b: 3'd0};
   localparam rgb_t RGB_LATE  = '{r: 3'd3, g: 3'd3, b: 3'd0};
   localparam rgb_t RGB_SHOW  = '{r: 3'd0, g: 3'd2, b: 3'd0};
   localparam rgb_t RGB_SUM   = '{r: 3'd0, g: 3'd0, b: 3'd2};

   // Galois form of x^16 + x^14 + x^13 + x^11 + 1
   localparam logic [15:0] LFSR_TAPS = 16'hB400;

   function automatic rgb_t state_rgb(state_t s);
      case (s)
         STIM:    return RGB_STIM;
         EARLY:   return RGB_EARLY;
         LATE:    return RGB_LATE;
         SHOW:    return RGB_SHOW;
         SUMMARY: return RGB_SUM;
         default: return RGB_OFF;
      endcase
   endfunction

endpackage

// File: rtl/reaction_timer_multiround_if.sv
// Button pulses in, LED colour and session statistics out.
interface reaction_timer_multiround_if #(
   parameter int RT_W = 14,
   parameter int RI_W = 3
);
   logic            start;
   logic            enter;
   logic [2:0]      color_r;
   logic [2:0]      color_g;
   logic [2:0]      color_b;
   logic [RT_W-1:0] result_ms;
   logic            result_valid;
   logic [RT_W-1:0] best_ms;
   logic [RT_W-1:0] avg_ms;
   logic [RI_W-1:0] round_idx;
   logic            busy;
   logic            early;
   logic            late;

   modport master (
      output start, enter,
      input  color_r, color_g, color_b,
      input  result_ms, result_valid, best_ms, avg_ms,
      input  round_idx, busy, early, late
   );

   modport slave (
      input  start, enter,
      output color_r, color_g, color_b,
      output result_ms, result_valid, best_ms, avg_ms,
      output round_idx, busy, early, late
   );
endinterface

// File: rtl/rt_lfsr16.sv
// Free-running 16-bit Galois LFSR used for the random foreperiod.
module rt_lfsr16
   import reaction_timer_pkg::*;
#(
   parameter logic [15:0] SEED = 16'hACE1
) (
   input  logic        clk,
   input  logic        RESET,
   input  logic        en,
   output logic [15:0] q
);

   always_ff @(posedge clk or negedge RESET) begin
      if (!RESET)
         q <= SEED;
      else if (en)
         q <= (q >> 1) ^ (q[0] ? LFSR_TAPS : 16'h0000);
   end

endmodule

// File: rtl/reaction_timer_multiround.sv
// Multi-round reaction timer: FSM, ms timebase, foreperiod and stats.
module reaction_timer_multiround
   import reaction_timer_pkg::*;
#(
   parameter int          TICKS_PER_MS    = 100000,
   parameter int          ROUNDS          = 4,
   parameter int          RT_W            = 14,
   parameter int          TIMEOUT_MS      = 1000,
   parameter int          PENALTY_MS      = 5000,
   parameter int          RWAIT_MIN_MS    = 1000,
   parameter int          RWAIT_SPAN_LOG2 = 12,
   parameter logic [15:0] LFSR_SEED       = 16'hACE1
) (
   input  logic clk,
   input  logic RESET,
   reaction_timer_multiround_if.slave bus
);

   localparam int RL    = $clog2(ROUNDS);
   localparam int RI_W  = RL + 1;
   localparam int SUM_W = RT_W + RL;
   localparam int PRE_W = (TICKS_PER_MS > 1) ? $clog2(TICKS_PER_MS) : 1;

   localparam logic [RT_W-1:0] TMO = RT_W'(TIMEOUT_MS);
   localparam logic [RT_W-1:0] PEN = RT_W'(PENALTY_MS);
   localparam logic [RT_W-1:0] RMN = RT_W'(RWAIT_MIN_MS);

   state_t             state, nxt;
   rgb_t               rgb;
   logic [PRE_W-1:0]   pre;
   logic               ms_tick;
   logic [RT_W-1:0]    ms_cnt;
   logic [RT_W-1:0]    target;
   logic [15:0]        lfsr;
   logic [SUM_W-1:0]   sum;
   logic [RI_W-1:0]    ri;
   logic [RT_W-1:0]    res_q, best_q, avg_q;
   logic               rv_q;
   logic               rec, clr, avg_ld;
   logic [RT_W-1:0]    rec_val;
   logic               unused_lfsr;

   rt_lfsr16 #(.SEED(LFSR_SEED)) u_lfsr (
      .clk   (clk),
      .RESET (RESET),
      .en    (1'b1),
      .q     (lfsr)
   );

   assign unused_lfsr = ^lfsr[15:RWAIT_SPAN_LOG2];

   assign ms_tick = (pre == PRE_W'(TICKS_PER_MS - 1));

   always_ff @(posedge clk or negedge RESET) begin
      if (!RESET)
         pre <= '0;
      else
         pre <= ms_tick ? '0 : pre + PRE_W'(1);
   end

   always_ff @(posedge clk or negedge RESET) begin
      if (!RESET)
         state <= IDLE;
      else
         state <= nxt;
   end

   always_comb begin
      nxt = state;
      unique case (state)
         IDLE:    if (bus.start) nxt = RWAIT;
         RWAIT:   if (ms_cnt == target) nxt = STIM;
                  else if (bus.enter) nxt = EARLY;
         STIM:    if (bus.enter) nxt = SHOW;
                  else if (ms_cnt == TMO) nxt = LATE;
         EARLY:   if (ms_cnt == PEN) nxt = RWAIT;
         LATE:    if (ms_cnt == PEN) nxt = SHOW;
         SHOW:    if (bus.start)
                     nxt = (ri < RI_W'(ROUNDS)) ? RWAIT : SUMMARY;
         SUMMARY: if (bus.start) nxt = RWAIT;
         default: nxt = IDLE;
      endcase
   end

   always_comb begin
      rgb     = state_rgb(state);
      rec     = 1'b0;
      rec_val = TMO;
      clr     = 1'b0;
      avg_ld  = 1'b0;
      unique case (1'b1)
         (state == STIM && nxt == SHOW): begin
            rec     = 1'b1;
            rec_val = ms_cnt;
         end
         (state == STIM && nxt == LATE): rec = 1'b1;
         ((state == IDLE || state == SUMMARY) && nxt == RWAIT):
            clr = 1'b1;
         (state == SHOW && nxt == SUMMARY): avg_ld = 1'b1;
         default: ;
      endcase
   end

   // Every state entry restarts the ms count from zero
   always_ff @(posedge clk or negedge RESET) begin
      if (!RESET)
         ms_cnt <= '0;
      else if (nxt != state)
         ms_cnt <= '0;
      else if (ms_tick && ms_cnt != '1)
         ms_cnt <= ms_cnt + RT_W'(1);
   end

   always_ff @(posedge clk or negedge RESET) begin
      if (!RESET)
         target <= '0;
      else if (state != RWAIT && nxt == RWAIT)
         target <= RMN + RT_W'(lfsr[RWAIT_SPAN_LOG2-1:0]);
   end

   always_ff @(posedge clk or negedge RESET) begin
      if (!RESET) begin
         res_q  <= '0;
         rv_q   <= 1'b0;
         best_q <= '1;
         avg_q  <= '0;
         ri     <= '0;
         sum    <= '0;
      end else begin
         rv_q <= rec;
         if (clr) begin
            sum    <= '0;
            ri     <= '0;
            best_q <= '1;
            avg_q  <= '0;
         end else if (rec) begin
            res_q <= rec_val;
            sum   <= sum + SUM_W'(rec_val);
            ri    <= ri + RI_W'(1);
            if (rec_val < best_q)
               best_q <= rec_val;
         end
         if (avg_ld)
            avg_q <= RT_W'(sum >> RL);
      end
   end

   assign bus.color_r      = rgb.r;
   assign bus.color_g      = rgb.g;
   assign bus.color_b      = rgb.b;
   assign bus.result_ms    = res_q;
   assign bus.result_valid = rv_q;
   assign bus.best_ms      = best_q;
   assign bus.avg_ms       = avg_q;
   assign bus.round_idx    = ri;
   assign bus.busy         = state inside {RWAIT, STIM, EARLY, LATE};
   assign bus.early        = (state == EARLY);
   assign bus.late         = (state == LATE);

endmodule

// File: tb/tb_reaction_timer_multiround.sv
// Scoreboard bench: round results queued at stimulus, popped on result_valid.
module tb_reaction_timer_multiround;
   import reaction_timer_pkg::*;

   localparam int TPM  = 4;
   localparam int RND  = 2;
   localparam int RTW  = 14;
   localparam int TMO  = 20;
   localparam int PEN  = 5;
   localparam int RMIN = 3;
   localparam int SPAN = 2;
   localparam int RIW  = $clog2(RND) + 1;
   localparam int ONES = (1 << RTW) - 1;

   logic clk   = 1'b0;
   logic RESET = 1'b0;

   always #5 clk = ~clk;

   reaction_timer_multiround_if #(.RT_W(RTW), .RI_W(RIW)) bus ();

   reaction_timer_multiround #(
      .TICKS_PER_MS    (TPM),
      .ROUNDS          (RND),
      .RT_W            (RTW),
      .TIMEOUT_MS      (TMO),
      .PENALTY_MS      (PEN),
      .RWAIT_MIN_MS    (RMIN),
      .RWAIT_SPAN_LOG2 (SPAN),
      .LFSR_SEED       (16'hACE1)
   ) dut (
      .clk   (clk),
      .RESET (RESET),
      .bus   (bus)
   );

   int checks = 0;
   int errors = 0;
   int rv_cnt = 0;
   int exp_q[$];
   int exp_v;

   task automatic chk(string tag, int got, int exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
      end
   endtask

   // Independent timebase and LFSR reference
   logic [1:0]  m_pre;
   logic [15:0] m_lfsr;

   always @(posedge clk or negedge RESET) begin
      if (!RESET) begin
         m_pre  <= 2'd0;
         m_lfsr <= 16'hACE1;
      end else begin
         m_pre  <= (m_pre == 2'd3) ? 2'd0 : m_pre + 2'd1;
         m_lfsr <= {1'b0, m_lfsr[15:1]} ^ (m_lfsr[0] ? 16'hB400 : 16'h0);
      end
   end

   always @(negedge clk) begin
      if (RESET && bus.result_valid) begin
         rv_cnt++;
         if (exp_q.size() == 0)
            chk("unexpected_result", 1, 0);
         else begin
            exp_v = exp_q.pop_front();
            chk("result_ms", int'(bus.result_ms), exp_v);
         end
      end
   end

   function automatic int rgb9();
      return int'({bus.color_r, bus.color_g, bus.color_b});
   endfunction

   function automatic state_t obs();
      if (bus.early) return EARLY;
      if (bus.late) return LATE;
      if (rgb9() == 'o222) return STIM;
      if (rgb9() == 'o020) return SHOW;
      if (rgb9() == 'o002) return SUMMARY;
      if (bus.busy) return RWAIT;
      return IDLE;
   endfunction

   int          tk;
   logic        last_tick;
   logic [15:0] lf_prev;
   int          n;
   int          tgt;
   int          rv0;

   task automatic step();
      lf_prev = m_lfsr;
      @(posedge clk);
      #1;
      last_tick = (m_pre == 2'd0);
      if (last_tick) tk++;
   endtask

   task automatic wait_st(input state_t s, output int ticks);
      int c  = 0;
      int ok = 0;
      while (ok == 0 && c < 400) begin
         step();
         c++;
         if (obs() == s) ok = 1;
      end
      chk($sformatf("reach_%s", s.name()), ok, 1);
      ticks = tk - int'(last_tick);
      tk = 0;
   endtask

   task automatic wait_tk(input int t);
      int c = 0;
      while (tk < t && c < 400) begin
         step();
         c++;
      end
   endtask

   task automatic pulse_start();
      bus.start = 1'b1;
      step();
      bus.start = 1'b0;
   endtask

   task automatic pulse_enter();
      bus.enter = 1'b1;
      step();
      bus.enter = 1'b0;
   endtask

   task automatic new_round();
      tk  = 0;
      tgt = RMIN + int'(lf_prev[SPAN-1:0]);
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: got timeout, expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      bus.start = 1'b0;
      bus.enter = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_rgb", rgb9(), 0);
      chk("rst_best", int'(bus.best_ms), ONES);
      chk("rst_res", int'(bus.result_ms), 0);
      chk("rst_avg", int'(bus.avg_ms), 0);
      chk("rst_ri", int'(bus.round_idx), 0);
      chk("rst_busy", int'(bus.busy), 0);
      @(negedge clk) RESET = 1'b1;
      @(posedge clk);
      #1;

      // normal session: 7 then 11
      pulse_start();
      new_round();
      chk("s1_rwait", int'(obs()), int'(RWAIT));
      wait_st(STIM, n);
      chk("s1_fore1", n, tgt);
      wait_tk(7);
      exp_q.push_back(7);
      pulse_enter();
      chk("s1_show1", int'(obs()), int'(SHOW));
      chk("s1_lat1", int'(bus.result_ms), 7);
      chk("s1_ri1", int'(bus.round_idx), 1);
      chk("s1_best1", int'(bus.best_ms), 7);
      pulse_start();
      new_round();
      chk("s1_rwait2", int'(obs()), int'(RWAIT));
      wait_st(STIM, n);
      chk("s1_fore2", n, tgt);
      wait_tk(11);
      exp_q.push_back(11);
      pulse_enter();
      chk("s1_ri2", int'(bus.round_idx), 2);
      chk("s1_best2", int'(bus.best_ms), 7);
      pulse_start();
      chk("s1_summary", int'(obs()), int'(SUMMARY));
      chk("s1_rgb", rgb9(), 'o002);
      chk("s1_avg", int'(bus.avg_ms), 9);
      chk("s1_rv", rv_cnt, 2);

      // early press, then late
      pulse_start();
      new_round();
      chk("s2_ri_clr", int'(bus.round_idx), 0);
      chk("s2_best_clr", int'(bus.best_ms), ONES);
      wait_tk(1);
      rv0 = rv_cnt;
      pulse_enter();
      tk = 0;
      chk("s2_early", int'(obs()), int'(EARLY));
      chk("s2_rgb", rgb9(), 'o100);
      wait_st(RWAIT, n);
      new_round();
      chk("s2_pen", n, PEN);
      chk("s2_ri", int'(bus.round_idx), 0);
      chk("s2_norv", rv_cnt, rv0);
      wait_st(STIM, n);
      chk("s2_fore", n, tgt);
      exp_q.push_back(TMO);
      wait_st(LATE, n);
      chk("s3_tmo", n, TMO);
      chk("s3_rgb", rgb9(), 'o330);
      wait_st(SHOW, n);
      chk("s3_pen", n, PEN);
      chk("s3_res", int'(bus.result_ms), TMO);
      chk("s3_ri", int'(bus.round_idx), 1);
      chk("s3_rv", rv_cnt, rv0 + 1);

      // simultaneous events
      pulse_start();
      new_round();
      wait_tk(tgt);
      pulse_enter();
      tk = 0;
      chk("s4_expiry_wins", int'(obs()), int'(STIM));
      wait_tk(TMO);
      exp_q.push_back(TMO);
      pulse_enter();
      chk("s4_enter_wins", int'(obs()), int'(SHOW));
      chk("s4_res", int'(bus.result_ms), TMO);
      chk("s4_ri", int'(bus.round_idx), 2);
      pulse_start();
      chk("s4_summary", int'(obs()), int'(SUMMARY));
      chk("s4_avg", int'(bus.avg_ms), TMO);

      // asynchronous reset in STIM
      pulse_start();
      new_round();
      wait_st(STIM, n);
      chk("s5_fore", n, tgt);
      wait_tk(3);
      #2 RESET = 1'b0;
      #1;
      chk("s5_rgb", rgb9(), 0);
      chk("s5_busy", int'(bus.busy), 0);
      chk("s5_best", int'(bus.best_ms), ONES);
      chk("s5_res", int'(bus.result_ms), 0);
      chk("s5_ri", int'(bus.round_idx), 0);
      chk("s5_avg", int'(bus.avg_ms), 0);
      @(negedge clk) RESET = 1'b1;
      @(posedge clk);
      #1;
      pulse_start();
      new_round();
      chk("s5_fresh", int'(obs()), int'(RWAIT));
      chk("s5_fresh_ri", int'(bus.round_idx), 0);

      // ignored inputs and truncating average
      wait_st(STIM, n);
      chk("s6_fore1", n, tgt);
      wait_tk(2);
      pulse_start();
      chk("s6_start_ign", int'(obs()), int'(STIM));
      wait_tk(4);
      exp_q.push_back(4);
      pulse_enter();
      chk("s6_show", int'(obs()), int'(SHOW));
      pulse_enter();
      chk("s6_enter_ign", int'(obs()), int'(SHOW));
      pulse_start();
      new_round();
      wait_st(STIM, n);
      chk("s6_fore2", n, tgt);
      wait_tk(7);
      exp_q.push_back(7);
      pulse_enter();
      chk("s6_best", int'(bus.best_ms), 4);
      pulse_start();
      chk("s6_summary", int'(obs()), int'(SUMMARY));
      chk("s6_avg", int'(bus.avg_ms), 5);

      step();
      step();
      chk("queue_empty", exp_q.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
